// File: rtl/cla4_adder_pkg.sv
// Shared constants and helpers for the look-ahead adder.
// Holds the look-ahead cell width and the cell-count calculation.
package cla4_adder_pkg;

    localparam int CELL_W = 4;

    // Number of look-ahead cells for a legal operand width.
    function automatic int cell_count(input int width);
        return width / CELL_W;
    endfunction

endpackage

// File: rtl/cla4_adder_cell.sv
// Combinational 4-bit carry look-ahead cell with flattened carries.
// Also produces the cell propagate and generate values for the group unit.
module cla4_cell
    import cla4_adder_pkg::*;
(
    input  logic [CELL_W-1:0] a,
    input  logic [CELL_W-1:0] b,
    input  logic              cin,
    output logic [CELL_W-1:0] s,
    output logic              cout,
    output logic              cp,
    output logic              cg
);

    logic [CELL_W-1:0] p_s;
    logic [CELL_W-1:0] g_s;
    logic              c1_s;
    logic              c2_s;
    logic              c3_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Each carry is a two-level sum of products taken straight from the bit
    // propagate/generate terms, so no carry feeds another carry.
    assign c1_s = g_s[0] | (p_s[0] & cin);
    assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c3_s = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign cg   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign cp   = &p_s;
    assign cout = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ {c3_s, c2_s, c1_s, cin};

endmodule

// File: rtl/cla4_adder.sv
// Registered carry look-ahead adder built from 4-bit cells and a
// second-level group look-ahead unit; exports group P/G for cascading.
module cla4_adder
    import cla4_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int N = cell_count(WIDTH);

    logic [N-1:0]     cell_p_s;
    logic [N-1:0]     cell_g_s;
    logic [N-1:0]     cell_cout_s;
    logic [N:0]       cell_cin_s;
    logic [WIDTH-1:0] sum_s;
    logic             grp_g_s;

    for (genvar i = 0; i < N; i++) begin : g_cell
        cla4_cell u_cell (
            .a    (a[i*CELL_W +: CELL_W]),
            .b    (b[i*CELL_W +: CELL_W]),
            .cin  (cell_cin_s[i]),
            .s    (sum_s[i*CELL_W +: CELL_W]),
            .cout (cell_cout_s[i]),
            .cp   (cell_p_s[i]),
            .cg   (cell_g_s[i])
        );
    end

    // Second-level look-ahead: every cell carry-in is an independent product
    // sum over lower cell P/G terms and c0, never a chain of cell carries.
    always_comb begin
        logic term;
        cell_cin_s = '0;
        grp_g_s    = 1'b0;
        term       = 1'b0;
        cell_cin_s[0] = c0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < k; j++) begin
                term = cell_g_s[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & cell_p_s[m];
                end
                cell_cin_s[k] = cell_cin_s[k] | term;
                if (k == N) begin
                    grp_g_s = grp_g_s | term;
                end else begin
                    grp_g_s = grp_g_s;
                end
            end
            term = c0;
            for (int m = 0; m < k; m++) begin
                term = term & cell_p_s[m];
            end
            cell_cin_s[k] = cell_cin_s[k] | term;
        end
    end

    // Output registers; reset wins over the operands present at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            carry <= 1'b0;
            grp_p <= 1'b0;
            grp_g <= 1'b0;
        end else begin
            sum   <= sum_s;
            carry <= cell_cout_s[N-1];
            grp_p <= &cell_p_s;
            grp_g <= grp_g_s;
        end
    end

endmodule

// File: tb/tb_cla4_adder.sv
// Scoreboard bench for cla4_adder at WIDTH=4 and WIDTH=16 sharing one stimulus
// stream; expectations come from integer arithmetic on the operands.
module tb_cla4_adder;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        gp;
        logic        gg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = 16'h0000;
    logic [15:0] b   = 16'h0000;
    logic        c0  = 1'b0;

    logic [3:0]  sum4;
    logic        carry4, gp4, gg4;
    logic [15:0] sum16;
    logic        carry16, gp16, gg16;

    exp_t q4[$];
    exp_t q16[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cla4_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a[3:0]), .b(b[3:0]), .c0(c0),
        .sum(sum4), .carry(carry4), .grp_p(gp4), .grp_g(gg4)
    );

    cla4_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c0(c0),
        .sum(sum16), .carry(carry16), .grp_p(gp16), .grp_g(gg16)
    );

    function automatic exp_t model(input int w, input logic [15:0] av_in,
                                   input logic [15:0] bv_in, input logic c,
                                   input logic r);
        exp_t e;
        int mask, av, bv, tot;
        mask = (1 << w) - 1;
        av   = int'(av_in) & mask;
        bv   = int'(bv_in) & mask;
        tot  = av + bv + int'(c);
        if (r) begin
            e.sum = 16'h0000; e.carry = 1'b0; e.gp = 1'b0; e.gg = 1'b0;
        end else begin
            e.sum   = 16'(tot & mask);
            e.carry = ((tot >> w) & 1) != 0;
            e.gp    = ((av ^ bv) == mask);
            e.gg    = (((av + bv) >> w) & 1) != 0;
        end
        return e;
    endfunction

    task automatic step(input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic r);
        @(negedge clk);
        a = av; b = bv; c0 = c; rst = r;
        q4.push_back(model(4, av, bv, c, r));
        q16.push_back(model(16, av, bv, c, r));
    endtask

    // Monitor: one registered result per cycle, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checks++;
            if (sum4 !== e.sum[3:0] || carry4 !== e.carry || gp4 !== e.gp || gg4 !== e.gg) begin
                errors++;
                $display("FAIL w4 got sum=%h c=%b p=%b g=%b want sum=%h c=%b p=%b g=%b",
                         sum4, carry4, gp4, gg4, e.sum[3:0], e.carry, e.gp, e.gg);
            end
        end
        if (q16.size() > 0) begin
            e = q16.pop_front();
            checks++;
            if (sum16 !== e.sum || carry16 !== e.carry || gp16 !== e.gp || gg16 !== e.gg) begin
                errors++;
                $display("FAIL w16 got sum=%h c=%b p=%b g=%b want sum=%h c=%b p=%b g=%b",
                         sum16, carry16, gp16, gg16, e.sum, e.carry, e.gp, e.gg);
            end
        end
    end

    initial begin
        // Reset held two cycles with operands present, then released.
        step(16'h000A, 16'h0003, 1'b0, 1'b1);
        step(16'h000A, 16'h0003, 1'b0, 1'b1);
        step(16'h000A, 16'h0003, 1'b0, 1'b0);
        // Directed vectors, back to back.
        step(16'h000E, 16'h0008, 1'b0, 1'b0);
        step(16'h0008, 16'h000B, 1'b0, 1'b0);
        step(16'h000E, 16'h0009, 1'b1, 1'b0);
        step(16'h000D, 16'h000B, 1'b1, 1'b0);
        step(16'h0000, 16'h000F, 1'b1, 1'b0);
        step(16'h0005, 16'h0008, 1'b1, 1'b0);
        step(16'h0000, 16'h0000, 1'b0, 1'b0);
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        step(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
        step(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
        // Mid-stream reset on the third vector of a continuous stream.
        for (int i = 0; i < 6; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom), (i == 2));
        end
        // Random stream with sporadic reset.
        for (int i = 0; i < 5000; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) == 0));
        end
        @(posedge clk);
        #2;
        checks++;
        if (q4.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", q4.size(), q16.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla4_adder.md
Name: cla4_adder

Overview:
- Registered 4-bit-group carry look-ahead adder: sum = a + b + c0, carry-out from look-ahead logic, no ripple between bits.
- Generic WIDTH, built from 4-bit look-ahead cells plus a second-level group look-ahead unit.
- Inputs are captured combinationally and results are registered on the clock edge.
- Serves as the datapath adder for the ALU; it also exports group propagate/generate signals for cascading.

Parameters:
- WIDTH, 4, operand width in bits. Must be a multiple of 4 and between 4 and 16.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c0  input  1  carry-in.
- sum  output  WIDTH  registered (a+b+c0) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a+b+c0.
- grp_p  output  1  registered group propagate, AND of all p_i.
- grp_g  output  1  registered group generate, equal to carry with c0 forced to 0.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- When rst=1 at a rising edge: sum, carry, grp_p and grp_g all become 0. rst takes priority over new operands.
- Otherwise, every rising edge registers the result of the a, b, c0 values present before the edge.
- Latency is 1 cycle and throughput is 1 result per cycle. There is no handshake and no enable.
- Per bit: p_i = a_i XOR b_i, g_i = a_i AND b_i, s_i = p_i XOR c_i.
- Cell carries are flattened two-level sum-of-products within a 4-bit cell:
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
- Each cell also produces a cell P (p3p2p1p0) and a cell G (c4 with c0=0).
- When WIDTH > 4, cell carry-ins come from the second-level look-ahead over the cell P/G values. Cells are never chained through c4 ripple.
- Arithmetic is unsigned modulo 2^WIDTH; overflow shows only on carry. No signed-overflow flag.
- Boundary cases:
  - all-ones + 0 + c0=1 gives sum=0, carry=1.
  - 0 + 0 + 0 gives sum=0, carry=0, grp_p=0.
  - all-ones + all-ones + 1 gives sum=all-ones, carry=1.
- Deasserting reset mid-stream: the first registered result is the one for operands present at the first edge with rst=0.
- The datapath has no X-propagation handling beyond standard RTL semantics.

Decomposition:
- Shared package: the WIDTH legality constant (CELL_W=4) and a function computing the cell count.
- Natural sub-module: cla4_cell. It is combinational, with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout, cp, cg. It is instantiated WIDTH/4 times.
- The top level contains the group look-ahead unit and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=1010, b=0011 -> sum=0000, carry=0, grp_p=0, grp_g=0. After release, one cycle later sum=1101, carry=0.
- Back-to-back, no c0, one cycle apart (WIDTH=4):
  - 1110+1000 -> sum=0110, carry=1
  - 1000+1011 -> sum=0011, carry=1
- With c0=1:
  - 1110+1001 -> sum=1000, carry=1
  - 1101+1011 -> sum=1001, carry=1
- Full propagate, 0000+1111 with c0=1 -> sum=0000, carry=1, grp_p=1, grp_g=0. Also 0101+1000 with c0=1 -> sum=1110, carry=0.
- Latency and mid-stream reset: apply a new vector every cycle and assert rst on cycle 3 -> outputs lag inputs by exactly 1 cycle, read 0 on the cycle after rst, then resume.
- WIDTH=16: 0xFFFF+0x0000 with c0=1 -> sum=0x0000, carry=1. Then 5000 random vectors checked against a reference (a+b+c0) model.
